serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
- Bit-serial add/subtract engine that consumes the per-bit sum and carry terms produced by the half-adder stage.
- Chains two half-adder evaluations per cycle with a registered carry to add or subtract two WIDTH-bit operands, LSB first.
- Sits downstream of the half-adder cell and upstream of result consumers. Uses a valid/ready handshake on both sides.
- Trades area for latency: one bit per clock.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  unit can accept operands (high only in IDLE)
a  input  WIDTH  operand A, sampled only on the accepting edge
b  input  WIDTH  operand B, sampled only on the accepting edge
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  0 = A+B+cin, 1 = A-B (computed as A+~B+1)
out_valid  output  1  result bundle valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result word
cout  output  1  carry out of MSB; for sub, 1 = no borrow
ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0: state=IDLE; all shift registers, the bit counter and the carry register clear to 0. Outputs are in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, busy=0. Reset asserted mid-RUN or mid-DONE aborts the operation immediately and the result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: load a_sh=a, b_sh=(sub ? ~b : b), carry=(sub ? 1 : cin), cnt=0, and capture sub. Go to RUN.
- RUN:
  - in_ready=0.
  - Per edge:
    - h1 = a_sh[0]^b_sh[0], g1 = a_sh[0]&b_sh[0]
    - s = h1^carry, g2 = h1&carry
    - carry <= g1|g2
    - result register shifts right with s entering at bit WIDTH-1
    - a_sh and b_sh shift right
    - cnt++
  - On the edge where cnt==WIDTH-2, record the carry-out of that bit as c_msb_in.
  - On the edge where cnt==WIDTH-1: go to DONE; cout <= final carry; ovf <= c_msb_in ^ final carry.
- DONE:
  - out_valid=1. sum, cout and ovf hold stable until the handshake.
  - On an edge with out_ready=1: go to IDLE and drop out_valid. sum, cout and ovf retain their last values.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles at best.
- No overlap: in_ready is low in DONE. An in_valid held during DONE is accepted no earlier than the edge after the out_ready handshake, i.e. the first IDLE edge.
- Input stability: a, b, cin and sub may change freely after acceptance; changes do not affect the result in flight.
- Backpressure: out_ready=0 holds DONE indefinitely with no result change.
- Arithmetic: all sums are modulo 2^WIDTH. A carry beyond the MSB goes only to cout.

Test Plan:
- Add, WIDTH=8: a=0x35, b=0x4A, cin=0, sub=0 -> sum=0x7F, cout=0, ovf=0. out_valid high exactly 8 edges after the accepting edge.
- Add with carry and overflow cases:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
  - a=0x00, b=0x00, cin=1 -> sum=0x01.
- Subtract:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> out_valid stays 1, sum/cout/ovf unchanged, in_ready=0. Then raise out_ready -> the next operation is accepted on the following IDLE edge and its result is correct.
- Reset mid-RUN: pull rst_n low after 3 RUN edges -> out_valid=0, busy=0, sum=0, in_ready=1 with no clock edge required. After release, a=0x12, b=0x34 -> sum=0x46, cout=0.
- Back-to-back: issue 20 random add/sub operations with in_valid and out_ready always high -> every result matches the reference model, and each operation takes WIDTH+2 cycles from accept to accept.

Source files
------------

// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract engine: one result bit per clock, LSB first, built from two
// chained half-adder evaluations and a registered carry, with valid/ready on both sides.
module serial_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             c_msb_in;
    logic             cout_q;
    logic             ovf_q;

    logic h1, g1, s_bit, g2, carry_nxt;
    logic last_bit, msb_in_bit;

    // Two half-adder stages: operand bits first, then the running carry.
    always_comb begin
        h1        = a_sh[0] ^ b_sh[0];
        g1        = a_sh[0] & b_sh[0];
        s_bit     = h1 ^ carry;
        g2        = h1 & carry;
        carry_nxt = g1 | g2;
    end

    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
    assign msb_in_bit = (cnt == CNT_W'(WIDTH - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    carry <= carry_nxt;
                    res   <= {s_bit, res[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (msb_in_bit) begin
                        c_msb_in <= carry_nxt;
                    end
                    if (last_bit) begin
                        cout_q <= carry_nxt;
                        ovf_q  <= c_msb_in ^ carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = res;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed and random checks for serial_addsub_unit at WIDTH=8.
module tb_serial_addsub_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    serial_addsub_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] e_sum;
        logic       e_cout;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid rises (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL timeout: out_valid not seen after %0d edges", n);
        end
    endtask

    // Reference: plain integer arithmetic.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mcin,
                         input logic msub, output logic [7:0] r, output logic c, output logic o);
        int sa, sb, sr;
        logic [8:0] full;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            full = {1'b0, ma} - {1'b0, mb};
            r    = full[7:0];
            c    = (ma >= mb);
            sr   = sa - sb;
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {8'd0, mcin};
            r    = full[7:0];
            c    = full[8];
            sr   = sa + sb + int'(mcin);
        end
        o = (sr > 127) || (sr < -128);
    endtask

    // Starts from IDLE; accepts one operation, checks latency and result, handshakes.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vcin, input logic vsub, input logic [7:0] es,
                          input logic ec, input logic eo, input logic keep_handshakes,
                          output int acc_cyc);
        int n;
        a = va; b = vb; cin = vcin; sub = vsub;
        in_valid = 1'b1;
        tick();
        acc_cyc = cyc;
        check({tag, " busy_after_accept"}, busy, 1'b1);
        if (!keep_handshakes) in_valid = 1'b0;
        a = ~va; b = va ^ vb; cin = ~vcin; sub = ~vsub;
        wait_done(n);
        check({tag, " latency"}, n, W);
        check({tag, " sum"}, sum, es);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, eo);
        if (!keep_handshakes) out_ready = 1'b1;
        tick();
        if (!keep_handshakes) out_ready = 1'b0;
        check({tag, " out_valid_dropped"}, out_valid, 1'b0);
        check({tag, " in_ready_idle"}, in_ready, 1'b1);
        check({tag, " sum_retained"}, sum, es);
    endtask

    initial begin
        int n, acc, last_acc;
        logic [7:0] ra, rb, es;
        logic rc, rs, ec, eo;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[9] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};

        #12;
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_valid", out_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst sum", sum, 8'h00);
        check("rst cout", cout, 1'b0);
        check("rst ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf, 1'b0, acc);
        end

        // Backpressure: DONE held with in_valid high and wandering operands.
        a = 8'h35; b = 8'h4A; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        wait_done(n);
        check("bp latency", n, W);
        for (int k = 0; k < 5; k++) begin
            a = 8'(k * 37 + 3); b = 8'(k * 91 + 5);
            tick();
            check("bp out_valid", out_valid, 1'b1);
            check("bp in_ready", in_ready, 1'b0);
            check("bp sum", sum, 8'h7F);
            check("bp cout", cout, 1'b0);
            check("bp ovf", ovf, 1'b0);
        end
        a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp idle in_ready", in_ready, 1'b1);
        check("bp idle busy", busy, 1'b0);
        tick();
        check("bp next accepted", busy, 1'b1);
        in_valid = 1'b0;
        a = 8'hAA; b = 8'hAA;
        wait_done(n);
        check("bp next latency", n, W);
        check("bp next sum", sum, 8'h30);
        check("bp next cout", cout, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of RUN.
        a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("midrst busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst sum", sum, 8'h00);
        check("midrst in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, acc);

        // Back-to-back random traffic with both handshakes held high.
        out_ready = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rc, rs, es, ec, eo);
            run_op($sformatf("rnd%0d", k), ra, rb, rc, rs, es, ec, eo, 1'b1, acc);
            if (k > 0) check("rnd accept_interval", acc - last_acc, W + 2);
            last_acc = acc;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
